// File: rtl/cal_coef_scheduler.sv
// Ping-pong calibration coefficient tables stepped once per ADC frame.
// Shadow writes, commit-at-boundary swap, frame marker protocol checking.
module cal_coef_scheduler #(
    parameter int TBL_DEPTH = 16,
    parameter int AW        = 4
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic          adc_data_cha_sop,
    input  logic          adc_data_cha_eop,
    input  logic          adc_data_cha_valid,
    input  logic          cfg_wr_en,
    input  logic [AW-1:0] cfg_wr_addr,
    input  logic [31:0]   cfg_wr_cha,
    input  logic [31:0]   cfg_wr_chb,
    input  logic [AW:0]   cfg_tbl_len,
    input  logic          cfg_commit,
    output logic          cfg_ready,
    output logic          commit_pending,
    output logic          tbl_valid,
    output logic [AW-1:0] coef_index,
    output logic [31:0]   Calibration_IQCHA,
    output logic [31:0]   Calibration_IQCHB,
    output logic          frame_err
);

    localparam logic [31:0] UNITY   = 32'h0000_1000;
    localparam logic [AW:0] DEPTH_L = TBL_DEPTH[AW:0];

    typedef enum logic {IDLE, IN_FRAME} state_t;

    state_t        state, state_n;
    logic          bank_sel, bank_sel_n;
    logic [AW-1:0] idx_n;
    logic          tbl_valid_n, pending_n;
    logic          applied, applied_n;
    logic [AW:0]   len, len_n;
    logic          eop_q;
    logic          err_n, boundary, accept, swap;
    logic          vsop, veop;

    logic [31:0] mem_a [0:2*TBL_DEPTH-1];
    logic [31:0] mem_b [0:2*TBL_DEPTH-1];
    logic [31:0] rd_a, rd_b;

    assign vsop      = adc_data_cha_valid & adc_data_cha_sop;
    assign veop      = adc_data_cha_valid & adc_data_cha_eop;
    assign cfg_ready = ~commit_pending;

    always_comb begin
        state_n     = state;
        err_n       = 1'b0;
        boundary    = 1'b0;
        bank_sel_n  = bank_sel;
        idx_n       = coef_index;
        tbl_valid_n = tbl_valid;
        pending_n   = commit_pending;
        applied_n   = 1'b0;
        len_n       = len;

        case (state)
            IDLE: begin
                if (vsop) begin
                    if (veop) boundary = 1'b1;
                    else      state_n  = IN_FRAME;
                    // sop landing right after an eop leaves no frame gap
                    if (eop_q) err_n = 1'b1;
                end else if (veop) begin
                    err_n = 1'b1;
                end
            end
            IN_FRAME: begin
                if (vsop) err_n = 1'b1;
                if (veop) begin
                    boundary = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        accept = cfg_commit & ~commit_pending;
        // An idle commit swaps at once; `applied` keeps pending visible one cycle
        swap   = (commit_pending & ~applied & boundary) |
                 (accept & (boundary | ((state == IDLE) & ~vsop)));

        if (accept) begin
            pending_n = 1'b1;
            applied_n = swap;
            if (cfg_tbl_len == '0)          len_n = {{AW{1'b0}}, 1'b1};
            else if (cfg_tbl_len > DEPTH_L) len_n = DEPTH_L;
            else                            len_n = cfg_tbl_len;
        end else if (applied | swap) begin
            pending_n = 1'b0;
        end

        if (swap) begin
            bank_sel_n  = ~bank_sel;
            idx_n       = '0;
            tbl_valid_n = 1'b1;
        end else if (boundary & tbl_valid) begin
            if ({1'b0, coef_index} >= len - 1'b1) idx_n = '0;
            else                                  idx_n = coef_index + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            bank_sel          <= 1'b0;
            coef_index        <= '0;
            tbl_valid         <= 1'b0;
            commit_pending    <= 1'b0;
            applied           <= 1'b0;
            len               <= {{AW{1'b0}}, 1'b1};
            eop_q             <= 1'b0;
            frame_err         <= 1'b0;
            Calibration_IQCHA <= UNITY;
            Calibration_IQCHB <= UNITY;
        end else begin
            state             <= state_n;
            bank_sel          <= bank_sel_n;
            coef_index        <= idx_n;
            tbl_valid         <= tbl_valid_n;
            commit_pending    <= pending_n;
            applied           <= applied_n;
            len               <= len_n;
            eop_q             <= boundary;
            frame_err         <= err_n;
            Calibration_IQCHA <= tbl_valid ? rd_a : UNITY;
            Calibration_IQCHB <= tbl_valid ? rd_b : UNITY;
        end
    end

    // Table RAM: read addressed by next-state bank/index, not reset
    always_ff @(posedge sys_clk) begin
        if (cfg_wr_en && !commit_pending) begin
            mem_a[{~bank_sel, cfg_wr_addr}] <= cfg_wr_cha;
            mem_b[{~bank_sel, cfg_wr_addr}] <= cfg_wr_chb;
        end
        rd_a <= mem_a[{bank_sel_n, idx_n}];
        rd_b <= mem_b[{bank_sel_n, idx_n}];
    end

endmodule
